// File: rtl/pio_in_edge_irq_if.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq_if
//   Avalon-MM slave bus bundle for the edge-capturing input PIO.
//
//   Transfer semantics (the only handshake on this bus):
//     - A write is accepted on the rising clk edge where chipselect=1 and
//       write_n=0. There is no waitrequest; every write completes in that cycle.
//     - readdata is registered from address on every clk edge (chipselect is
//       not required). A read therefore has a fixed latency of one cycle: the
//       value for the address presented before edge N is valid after edge N.
//
//   Signals
//     address     [1:0]   word address (0 DATA, 1 MASK, 2 EDGE, 3 INFO)
//     chipselect          slave select, qualifies write_n
//     write_n             write strobe, active low
//     writedata   [31:0]  write data
//     readdata    [31:0]  registered read data
// -----------------------------------------------------------------------------
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq
//   Parametrised Avalon-MM input PIO with programmable edge capture and a
//   maskable interrupt. DATA_WIDTH asynchronous inputs are synchronised, edges
//   of the selected polarity are latched into a sticky capture register
//   (write-1-to-clear), and an interrupt is raised from either the captured
//   edges or the live input levels, gated by a per-bit mask.
//
//   Parameters
//     DATA_WIDTH   1..32  number of input bits
//     SYNC_STAGES  2..4   synchroniser depth
//     EDGE_TYPE    0 rising, 1 falling, 2 any edge
//     IRQ_TYPE     0 level (data & mask), 1 edge (edgecapture & mask)
//
//   Ports
//     i_clk        system clock (single domain)
//     i_reset      synchronous active-high reset
//     bus          Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//     i_in_port    asynchronous external inputs
//     o_irq        registered interrupt request, active high
//     o_dbg_armed  high once the post-reset arm delay has elapsed and edge
//                  detection is live (observability of the arm sequencer)
//
//   Register map (unused upper bits read 0, writes to them are ignored)
//     0 DATA  RO    synchronised inputs
//     1 MASK  RW    interrupt enable per bit
//     2 EDGE  RW1C  sticky edge capture
//     3 INFO  RO    {22'd0, IRQ_TYPE[0], EDGE_TYPE[1:0], 1'b0, DATA_WIDTH[5:0]}
// -----------------------------------------------------------------------------
module pio_in_edge_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  pio_in_edge_irq_if.slave      bus,
  input  logic [DATA_WIDTH-1:0] i_in_port,
  output logic                  o_irq,
  output logic                  o_dbg_armed
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // The arm counter runs 0..SYNC_STAGES+1. SYNC_STAGES is at most 4, so three
  // bits cover the full range.
  localparam logic [2:0] ARM_MAX   = 3'(SYNC_STAGES + 1);
  localparam logic [1:0] P_EDGE    = 2'(EDGE_TYPE);
  localparam logic       P_IRQ_EDG = (IRQ_TYPE != 0);
  localparam logic [5:0] P_DW      = 6'(DATA_WIDTH);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_INFO = 2'd3;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [2:0]            r_arm_cnt;
  logic [31:0]           r_readdata;
  logic                  r_irq;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_sync_q;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_edge_sel;
  logic [DATA_WIDTH-1:0] w_det;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_cap_next;
  logic                  w_armed;
  logic                  w_wr_en;
  logic                  w_wr_mask;
  logic                  w_wr_edge;
  logic                  w_irq_src;
  logic [31:0]           w_data_ext;
  logic [31:0]           w_mask_ext;
  logic [31:0]           w_cap_ext;
  logic [31:0]           w_info;
  logic [31:0]           w_rd_mux;

  // ---------------------------------------------------------------------------
  // Input synchroniser and previous-value register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync_q;
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Arm sequencer
  //   After reset the synchroniser and prev register hold zero while the pins
  //   may already be high; the first values to ripple through would look like
  //   rising edges. Detection stays off until the chain and prev have both
  //   been refilled from the live inputs (SYNC_STAGES+1 cycles).
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arm_cnt <= 3'd0;
    end else if (r_arm_cnt != ARM_MAX) begin
      r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  assign w_armed     = (r_arm_cnt == ARM_MAX);
  assign o_dbg_armed = w_armed;

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  assign w_rise = w_sync_q & ~r_prev;
  assign w_fall = ~w_sync_q & r_prev;

  always_comb begin
    w_edge_sel = '0;
    case (P_EDGE)
      2'd0:    w_edge_sel = w_rise;
      2'd1:    w_edge_sel = w_fall;
      default: w_edge_sel = w_rise | w_fall;
    endcase
  end

  assign w_det = w_armed ? w_edge_sel : '0;

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  assign w_wr_en   = bus.chipselect & ~bus.write_n;
  assign w_wr_mask = w_wr_en & (bus.address == ADDR_MASK);
  assign w_wr_edge = w_wr_en & (bus.address == ADDR_EDGE);
  assign w_clr     = w_wr_edge ? bus.writedata[DATA_WIDTH-1:0] : '0;

  // Only the low DATA_WIDTH bits of writedata are meaningful.
  generate
    if (DATA_WIDTH < 32) begin : g_wdata_hi
      logic w_unused_wdata_hi;
      assign w_unused_wdata_hi = &{1'b0, bus.writedata[31:DATA_WIDTH]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mask and edge capture registers
  //   A detect in the same cycle as a write-1-clear wins, so an edge arriving
  //   while software acknowledges an older one is never lost.
  // ---------------------------------------------------------------------------
  assign w_cap_next = (r_cap & ~w_clr) | w_det;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      if (w_wr_mask) begin
        r_mask <= bus.writedata[DATA_WIDTH-1:0];
      end
      r_cap <= w_cap_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: zero-extend to the 32-bit bus and register from address.
  //   readdata follows address even without chipselect, matching the
  //   single-bit PIO this block replaces.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data_ext = '0;
    w_mask_ext = '0;
    w_cap_ext  = '0;
    w_data_ext[DATA_WIDTH-1:0] = w_sync_q;
    w_mask_ext[DATA_WIDTH-1:0] = r_mask;
    w_cap_ext[DATA_WIDTH-1:0]  = r_cap;
  end

  assign w_info = {16'd0, 6'd0, P_IRQ_EDG, P_EDGE, 1'b0, P_DW};

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux = w_data_ext;
      ADDR_MASK: w_rd_mux = w_mask_ext;
      ADDR_EDGE: w_rd_mux = w_cap_ext;
      ADDR_INFO: w_rd_mux = w_info;
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;

  // ---------------------------------------------------------------------------
  // Interrupt: registered from the current capture (edge mode) or the
  //   synchronised levels (level mode), so a mask write is seen one cycle later.
  // ---------------------------------------------------------------------------
  assign w_irq_src = P_IRQ_EDG ? |(r_cap & r_mask) : |(w_sync_q & r_mask);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_src;
    end
  end

  assign o_irq = r_irq;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// tb_pio_in_edge_irq
//   Three instances with different parameter sets share one Avalon bus and one
//   input vector. Each is tracked by a cycle model built from the register-map
//   rules: the synchronised value is the input sampled SYNC_STAGES cycles ago,
//   detection is enabled once SYNC_STAGES+1 cycles have passed since reset.
//     u0: DATA_WIDTH 8,  SYNC 2, rising,  edge irq
//     u1: DATA_WIDTH 32, SYNC 3, any,     level irq
//     u2: DATA_WIDTH 5,  SYNC 4, falling, edge irq
// -----------------------------------------------------------------------------
module tb_pio_in_edge_irq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Shared stimulus
  // ---------------------------------------------------------------------------
  logic [1:0]  t_addr;
  logic        t_cs;
  logic        t_wn;
  logic [31:0] t_wd;
  logic [31:0] t_in;
  logic        chk_en;

  pio_in_edge_irq_if bus0 ();
  pio_in_edge_irq_if bus1 ();
  pio_in_edge_irq_if bus2 ();

  assign bus0.address = t_addr;  assign bus0.chipselect = t_cs;
  assign bus0.write_n = t_wn;    assign bus0.writedata  = t_wd;
  assign bus1.address = t_addr;  assign bus1.chipselect = t_cs;
  assign bus1.write_n = t_wn;    assign bus1.writedata  = t_wd;
  assign bus2.address = t_addr;  assign bus2.chipselect = t_cs;
  assign bus2.write_n = t_wn;    assign bus2.writedata  = t_wd;

  logic irq0, irq1, irq2;
  logic arm0, arm1, arm2;

  pio_in_edge_irq #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) u0 (
    .i_clk(clk), .i_reset(rst), .bus(bus0), .i_in_port(t_in[7:0]),
    .o_irq(irq0), .o_dbg_armed(arm0));

  pio_in_edge_irq #(.DATA_WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_TYPE(0)) u1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1), .i_in_port(t_in),
    .o_irq(irq1), .o_dbg_armed(arm1));

  pio_in_edge_irq #(.DATA_WIDTH(5), .SYNC_STAGES(4), .EDGE_TYPE(1), .IRQ_TYPE(1)) u2 (
    .i_clk(clk), .i_reset(rst), .bus(bus2), .i_in_port(t_in[4:0]),
    .o_irq(irq2), .o_dbg_armed(arm2));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0][31:0] hist;  // hist[k]: input sampled k+1 cycles ago
    logic [31:0]      age;   // cycles since reset (saturating)
    logic [31:0]      mask;
    logic [31:0]      cap;
    logic [31:0]      rd;
    logic             irq;
  } mdl_t;

  mdl_t m0, m1, m2;

  function automatic mdl_t model_next(input mdl_t m, input int dw, input int s,
                                      input int et, input int it, input logic rs,
                                      input logic [1:0] a, input logic cs, input logic wn,
                                      input logic [31:0] wd, input logic [31:0] inp);
    mdl_t nx;
    logic [31:0] wm, sy, pv, det, info, clr;
    bit we;
    wm = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    nx = m;
    if (rs) begin
      nx = '0;
      return nx;
    end
    sy = m.hist[s-1];
    pv = m.hist[s];
    case (et)
      0:       det = sy & ~pv;
      1:       det = ~sy & pv;
      default: det = sy ^ pv;
    endcase
    if (m.age < 32'(s + 1)) det = '0;
    we   = cs && !wn;
    info = 32'(dw) | (32'(et) << 7) | (32'(it) << 9);
    case (a)
      2'd0:    nx.rd = sy;
      2'd1:    nx.rd = m.mask;
      2'd2:    nx.rd = m.cap;
      default: nx.rd = info;
    endcase
    nx.irq = (it != 0) ? |(m.cap & m.mask) : |(sy & m.mask);
    clr    = (we && a == 2'd2) ? wd : 32'd0;
    nx.cap = ((m.cap & ~clr) | det) & wm;
    if (we && a == 2'd1) nx.mask = wd & wm;
    for (int i = 7; i > 0; i--) nx.hist[i] = m.hist[i-1];
    nx.hist[0] = inp & wm;
    if (m.age < 32'd100) nx.age = m.age + 32'd1;
    return nx;
  endfunction

  always @(posedge clk) begin
    m0 = model_next(m0, 8,  2, 0, 1, rst, t_addr, t_cs, t_wn, t_wd, t_in);
    m1 = model_next(m1, 32, 3, 2, 0, rst, t_addr, t_cs, t_wn, t_wd, t_in);
    m2 = model_next(m2, 5,  4, 1, 1, rst, t_addr, t_cs, t_wn, t_wd, t_in);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("rd0",  bus0.readdata, m0.rd);
      check_eq("irq0", {31'd0, irq0}, {31'd0, m0.irq});
      check_eq("arm0", {31'd0, arm0}, {31'd0, m0.age >= 32'd3});
      check_eq("rd1",  bus1.readdata, m1.rd);
      check_eq("irq1", {31'd0, irq1}, {31'd0, m1.irq});
      check_eq("arm1", {31'd0, arm1}, {31'd0, m1.age >= 32'd4});
      check_eq("rd2",  bus2.readdata, m2.rd);
      check_eq("irq2", {31'd0, irq2}, {31'd0, m2.irq});
      check_eq("arm2", {31'd0, arm2}, {31'd0, m2.age >= 32'd5});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    t_cs = 1'b0;
    t_wn = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    t_addr = a; t_cs = 1'b1; t_wn = 1'b0; t_wd = d;
    @(negedge clk);
    t_cs = 1'b0; t_wn = 1'b1;
  endtask

  // Returns at the negedge where the registered read value is valid.
  task automatic bus_read(input logic [1:0] a);
    t_addr = a; t_cs = 1'b1; t_wn = 1'b1;
    @(negedge clk);
    t_cs = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int found;
    chk_en = 1'b0;
    rst    = 1'b1;
    t_addr = 2'd0; t_cs = 1'b0; t_wn = 1'b1; t_wd = '0;
    t_in   = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_eq("rst_rd0", bus0.readdata, 32'd0);
    check_eq("rst_irq0", {31'd0, irq0}, 32'd0);
    rst = 1'b0;

    // Inputs high through reset: no false edges, DATA tracks the pins.
    idle(8);
    bus_read(2'd2);
    check_eq("t1_edge0", bus0.readdata, 32'd0);
    check_eq("t1_edge1", bus1.readdata, 32'd0);
    check_eq("t1_edge2", bus2.readdata, 32'd0);
    bus_read(2'd0);
    check_eq("t1_data0", bus0.readdata, 32'h0000_00FF);
    check_eq("t1_data1", bus1.readdata, 32'hFFFF_FFFF);
    check_eq("t1_irq0", {31'd0, irq0}, 32'd0);

    bus_read(2'd3);
    check_eq("info0", bus0.readdata, 32'h0000_0208);
    check_eq("info1", bus1.readdata, 32'h0000_0120);
    check_eq("info2", bus2.readdata, 32'h0000_0285);

    // Rising edge on bit 3, masked in; acknowledge it.
    t_in = 32'd0;
    idle(6);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'h08);
    t_in = 32'h08;
    idle(5);
    bus_read(2'd2);
    check_eq("t2_edge", bus0.readdata, 32'h08);
    check_eq("t2_irq_on", {31'd0, irq0}, 32'd1);
    bus_write(2'd2, 32'h08);
    idle(1);
    check_eq("t2_irq_off", {31'd0, irq0}, 32'd0);
    bus_read(2'd2);
    check_eq("t2_edge_clr", bus0.readdata, 32'd0);

    // Bit 0 edge detected on the same edge as a clear of bit 0.
    bus_write(2'd1, 32'h09);
    t_in = 32'h09;
    idle(2);
    bus_write(2'd2, 32'h01);
    idle(1);
    check_eq("t3_irq", {31'd0, irq0}, 32'd1);
    bus_read(2'd2);
    check_eq("t3_edge", bus0.readdata, 32'h01);

    // Any-edge pulse on bit 5 (u1); writing 0 to EDGE is a no-op.
    bus_write(2'd1, 32'd0);
    t_in = 32'h29;
    idle(6);
    bus_write(2'd2, 32'hFFFF_FFFF);
    t_in = 32'h09;
    idle(6);
    t_in = 32'h29;
    idle(6);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2);
    check_eq("t4_edge", bus1.readdata, 32'h20);
    check_eq("t4_irq", {31'd0, irq1}, 32'd0);

    // Level interrupt on u1 follows bit 0 within SYNC_STAGES+2 cycles.
    t_in = 32'd0;
    idle(8);
    bus_write(2'd1, 32'h01);
    idle(2);
    check_eq("t5_irq_idle", {31'd0, irq1}, 32'd0);
    t_in  = 32'h01;
    found = 0;
    for (int k = 0; k < 5 && found == 0; k++) begin
      @(negedge clk);
      if (irq1) found = 1;
    end
    check_eq("t5_irq_rise", 32'(found), 32'd1);
    t_in  = 32'd0;
    found = 0;
    for (int k = 0; k < 5 && found == 0; k++) begin
      @(negedge clk);
      if (!irq1) found = 1;
    end
    check_eq("t5_irq_fall", 32'(found), 32'd1);

    // Reset mid-stream with a busy input pattern.
    bus_write(2'd1, 32'hFFFF_FFFF);
    t_in = 32'hA5A5_5A5A;
    idle(8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_rd0", bus0.readdata, 32'd0);
    check_eq("t6_rd1", bus1.readdata, 32'd0);
    check_eq("t6_rd2", bus2.readdata, 32'd0);
    check_eq("t6_irq1", {31'd0, irq1}, 32'd0);
    bus_read(2'd1);
    check_eq("t6_mask1", bus1.readdata, 32'd0);
    idle(5);
    bus_read(2'd0);
    check_eq("t6_data1", bus1.readdata, 32'hA5A5_5A5A);
    check_eq("t6_data0", bus0.readdata, 32'h0000_005A);
    bus_read(2'd2);
    check_eq("t6_edge1", bus1.readdata, 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      t_addr = 2'($urandom_range(0, 3));
      t_cs   = ($urandom_range(0, 3) != 0);
      t_wn   = ($urandom_range(0, 2) != 0);
      t_wd   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 3) == 0) t_in = t_in ^ ($urandom & $urandom & $urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
